// File: rtl/top_pkg.sv
// top_pkg: FSM states, LCD opcodes, init/window byte sequences and colour palette
package top_pkg;

    typedef enum logic [2:0] {
        RST_LOW, RST_WAIT, INIT, INIT_WAIT, WAIT_TE, WINDOW, PIXELS
    } state_t;

    typedef enum logic [1:0] {WR_IDLE, WR_LOW, WR_HIGH} wr_ph_t;

    // One init step: bus byte, its rs level, whether a delay follows, end of sequence
    typedef struct packed {
        logic       rs;
        logic [7:0] b;
        logic       hold;
        logic       last;
    } init_t;

    localparam logic [7:0] OP_SWRESET = 8'h01;
    localparam logic [7:0] OP_SLPOUT  = 8'h11;
    localparam logic [7:0] OP_COLMOD  = 8'h3A;
    localparam logic [7:0] OP_MADCTL  = 8'h36;
    localparam logic [7:0] OP_INVON   = 8'h21;
    localparam logic [7:0] OP_TEON    = 8'h35;
    localparam logic [7:0] OP_DISPON  = 8'h29;
    localparam logic [7:0] OP_CASET   = 8'h2A;
    localparam logic [7:0] OP_RASET   = 8'h2B;
    localparam logic [7:0] OP_RAMWR   = 8'h2C;

    localparam logic [3:0] WIN_LAST = 4'd10;

    // Entry 0 is the rightmost: red, green, blue, white
    localparam logic [3:0][15:0] PALETTE = {16'hFFFF, 16'h001F, 16'h07E0, 16'hF800};

    function automatic init_t init_rom(input logic [3:0] s);
        case (s)
            4'd0:    return '{1'b0, OP_SWRESET, 1'b1, 1'b0};
            4'd1:    return '{1'b0, OP_SLPOUT,  1'b1, 1'b0};
            4'd2:    return '{1'b0, OP_COLMOD,  1'b0, 1'b0};
            4'd3:    return '{1'b1, 8'h55,      1'b0, 1'b0};
            4'd4:    return '{1'b0, OP_MADCTL,  1'b0, 1'b0};
            4'd5:    return '{1'b1, 8'h00,      1'b0, 1'b0};
            4'd6:    return '{1'b0, OP_INVON,   1'b0, 1'b0};
            4'd7:    return '{1'b0, OP_TEON,    1'b0, 1'b0};
            4'd8:    return '{1'b1, 8'h00,      1'b0, 1'b0};
            default: return '{1'b0, OP_DISPON,  1'b0, 1'b1};
        endcase
    endfunction

    // Returns {rs, byte} for window step s given last column h and last row v
    function automatic logic [8:0] win_rom(input logic [3:0] s, input logic [15:0] h, input logic [15:0] v);
        case (s)
            4'd0:       return {1'b0, OP_CASET};
            4'd1, 4'd2: return {1'b1, 8'h00};
            4'd3:       return {1'b1, h[15:8]};
            4'd4:       return {1'b1, h[7:0]};
            4'd5:       return {1'b0, OP_RASET};
            4'd6, 4'd7: return {1'b1, 8'h00};
            4'd8:       return {1'b1, v[15:8]};
            4'd9:       return {1'b1, v[7:0]};
            default:    return {1'b0, OP_RAMWR};
        endcase
    endfunction

endpackage

// File: rtl/top_lcd_write.sv
// lcd_write: two-clock 8080 write strobe (wrn low then high, db/rs held across both)
import top_pkg::*;

module lcd_write (
    input  logic       clk8,
    input  logic       rst,
    input  logic       start,
    input  logic       sel,
    input  logic [7:0] data,
    output logic       wrn,
    output logic       rs,
    output logic [7:0] db,
    output logic       busy,
    output logic       done
);

    wr_ph_t ph;

    // A start in the high cycle chains the next write with no idle clock
    always_ff @(posedge clk8 or posedge rst) begin
        if (rst) begin
            ph  <= WR_IDLE;
            wrn <= 1'b1;
            rs  <= 1'b1;
            db  <= 8'h00;
        end else if (start && ph != WR_LOW) begin
            ph  <= WR_LOW;
            wrn <= 1'b0;
            rs  <= sel;
            db  <= data;
        end else if (ph == WR_LOW) begin
            ph  <= WR_HIGH;
            wrn <= 1'b1;
        end else begin
            ph  <= WR_IDLE;
        end
    end

    assign busy = ph != WR_IDLE;
    assign done = ph == WR_HIGH;

endmodule

// File: rtl/top.sv
// top: 8080 LCD controller - panel reset, init, full-screen fill in a palette colour
// chosen by keypad_up. Define TE_SYNC_EN to start each frame on an lcd_fmark rising edge.
import top_pkg::*;

module top #(
    parameter int H_RES        = 240,
    parameter int V_RES        = 240,
    parameter int RST_CYCLES   = 256,
    parameter int DELAY_CYCLES = 1024
) (
    input  logic       clk8,
    input  logic       rst,
    input  logic       lcd_fmark,
    input  logic       keypad_up,
    output logic [7:0] lcd_db,
    output logic       lcd_csn,
    output logic       lcd_rs,
    output logic       lcd_wrn,
    output logic       lcd_rdn,
    output logic       lcd_resn,
    output logic       lcd_bl
);

    localparam int CW = $clog2((RST_CYCLES > DELAY_CYCLES ? RST_CYCLES : DELAY_CYCLES) + 1);
    localparam int PW = $clog2(H_RES * V_RES + 1);
    localparam logic [15:0] H_LAST = 16'(H_RES - 1);
    localparam logic [15:0] V_LAST = 16'(V_RES - 1);

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [3:0]      step, step_nx;
    logic [PW-1:0]   pix, pix_nx;
    logic            hl, hl_nx;
    logic [1:0]      idx, idx_nx, pending;
    logic            bl, bl_nx, resn, resn_nx, csn;
    logic            start, sel, busy, done, ready, te_go, press;
    logic [7:0]      data;
    logic [2:0]      kp_s;
    init_t           irom;
    logic [8:0]      wv;
    logic [15:0]     color;

`ifdef TE_SYNC_EN
    logic [2:0] fm_s;
    // Two synchroniser stages plus a delayed copy for rising-edge detection
    always_ff @(posedge clk8 or posedge rst) begin
        if (rst) fm_s <= 3'b000;
        else     fm_s <= {fm_s[1:0], lcd_fmark};
    end
    assign te_go = fm_s[1] & ~fm_s[2];
`else
    logic unused_fmark;
    assign unused_fmark = lcd_fmark;
    assign te_go = 1'b1;
`endif

    // Keypad synchroniser idles high (released); a held button gives one falling edge
    always_ff @(posedge clk8 or posedge rst) begin
        if (rst) kp_s <= 3'b111;
        else     kp_s <= {kp_s[1:0], keypad_up};
    end
    assign press = kp_s[2] & ~kp_s[1];

    // Pending colour advances per press; it reaches idx only at frame start
    always_ff @(posedge clk8 or posedge rst) begin
        if (rst)        pending <= 2'd0;
        else if (press) pending <= pending + 2'd1;
    end

    assign ready = !busy || done;
    assign irom  = init_rom(step);
    assign wv    = win_rom(step, H_LAST, V_LAST);
    assign color = PALETTE[idx];

    // Next-state and write requests; RST_WAIT ends one clock early because the
    // INIT clock that issues SWRESET completes the post-reset delay
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        step_nx  = step;
        pix_nx   = pix;
        hl_nx    = hl;
        idx_nx   = idx;
        bl_nx    = bl;
        resn_nx  = resn;
        start    = 1'b0;
        sel      = 1'b1;
        data     = 8'h00;
        case (state)
            RST_LOW: begin
                if (cnt == CW'(RST_CYCLES - 1)) begin
                    state_nx = RST_WAIT;
                    cnt_nx   = '0;
                    resn_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            RST_WAIT: begin
                if (cnt == CW'(DELAY_CYCLES - 2)) begin
                    state_nx = INIT;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            INIT: begin
                if (ready) begin
                    start   = 1'b1;
                    sel     = irom.rs;
                    data    = irom.b;
                    step_nx = step + 4'd1;
                    if (irom.last) begin
                        state_nx = WAIT_TE;
                        bl_nx    = 1'b1;
                        step_nx  = 4'd0;
                    end else if (irom.hold) begin
                        state_nx = INIT_WAIT;
                    end
                end
            end
            INIT_WAIT: begin
                if (cnt == CW'(DELAY_CYCLES - 1)) begin
                    state_nx = INIT;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            WAIT_TE: begin
                if (te_go) begin
                    state_nx = WINDOW;
                    idx_nx   = pending;
                    step_nx  = 4'd0;
                end
            end
            WINDOW: begin
                if (ready) begin
                    start       = 1'b1;
                    {sel, data} = wv;
                    step_nx     = step + 4'd1;
                    if (step == WIN_LAST) begin
                        state_nx = PIXELS;
                        step_nx  = 4'd0;
                        pix_nx   = '0;
                        hl_nx    = 1'b0;
                    end
                end
            end
            PIXELS: begin
                if (ready) begin
                    start = 1'b1;
                    data  = hl ? color[7:0] : color[15:8];
                    hl_nx = ~hl;
                    if (hl) begin
                        if (pix == PW'(H_RES * V_RES - 1)) begin
                            state_nx = WAIT_TE;
                            pix_nx   = '0;
                        end else begin
                            pix_nx = pix + PW'(1);
                        end
                    end
                end
            end
            default: state_nx = RST_LOW;
        endcase
    end

    // State and sequencing registers; chip select drops with the first write
    always_ff @(posedge clk8 or posedge rst) begin
        if (rst) begin
            state <= RST_LOW;
            cnt   <= '0;
            step  <= 4'd0;
            pix   <= '0;
            hl    <= 1'b0;
            idx   <= 2'd0;
            bl    <= 1'b0;
            resn  <= 1'b0;
            csn   <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            step  <= step_nx;
            pix   <= pix_nx;
            hl    <= hl_nx;
            idx   <= idx_nx;
            bl    <= bl_nx;
            resn  <= resn_nx;
            if (start) csn <= 1'b0;
        end
    end

    lcd_write u_wr (
        .clk8  (clk8),
        .rst   (rst),
        .start (start),
        .sel   (sel),
        .data  (data),
        .wrn   (lcd_wrn),
        .rs    (lcd_rs),
        .db    (lcd_db),
        .busy  (busy),
        .done  (done)
    );

    assign lcd_csn  = csn;
    assign lcd_rdn  = 1'b1;
    assign lcd_resn = resn;
    assign lcd_bl   = bl;

endmodule

// File: tb/tb_top.sv
// tb_top: directed bench for top - reset timing, init sequence, window, frame colours, keypad, mid-frame reset
module tb_top;

    localparam int H = 260;
    localparam int V = 2;
    localparam int NPX = H * V;

    logic       clk8 = 1'b0;
    logic       rst = 1'b0;
    logic       lcd_fmark = 1'b1;
    logic       keypad_up = 1'b1;
    logic [7:0] lcd_db;
    logic       lcd_csn, lcd_rs, lcd_wrn, lcd_rdn, lcd_resn, lcd_bl;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int proto_bad = 0;
    bit dead = 1'b0;

    typedef struct {
        logic [7:0] b;
        logic       rs;
        logic       ok;
        logic       bl;
    } wr_t;
    wr_t q[$];

    logic [8:0] init_exp [10] = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h100, 9'h021, 9'h035, 9'h100, 9'h029};
    logic [8:0] win_exp [11] = '{9'h02A, 9'h100, 9'h100, 9'h101, 9'h103, 9'h02B, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02C};

    top #(.H_RES(H), .V_RES(V), .RST_CYCLES(256), .DELAY_CYCLES(1024)) dut (
        .clk8      (clk8),
        .rst       (rst),
        .lcd_fmark (lcd_fmark),
        .keypad_up (keypad_up),
        .lcd_db    (lcd_db),
        .lcd_csn   (lcd_csn),
        .lcd_rs    (lcd_rs),
        .lcd_wrn   (lcd_wrn),
        .lcd_rdn   (lcd_rdn),
        .lcd_resn  (lcd_resn),
        .lcd_bl    (lcd_bl)
    );

    always #5 clk8 = ~clk8;

    always @(posedge clk8) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Capture every completed write at the wrn rising edge, with a protocol verdict
    int         low_n = 0;
    logic [8:0] low_v = '0;
    logic       wprev = 1'b1;
    always @(negedge clk8) begin
        if (rst) begin
            low_n = 0;
            wprev = 1'b1;
        end else begin
            if (!lcd_wrn) begin
                low_n++;
                low_v = {lcd_rs, lcd_db};
            end else if (!wprev) begin
                q.push_back('{lcd_db, lcd_rs, (low_n == 1) && (low_v == {lcd_rs, lcd_db}) && !lcd_csn, lcd_bl});
                low_n = 0;
            end
            wprev = lcd_wrn;
        end
    end

    task automatic get_wr(output logic [8:0] v, output logic blv);
        int n = 0;
        v = '0;
        blv = 1'b0;
        while (!dead && q.size() == 0 && n < 3000) begin
            @(negedge clk8);
            n++;
        end
        if (q.size() == 0) begin
            if (!dead) begin
                dead = 1'b1;
                chk("write_timeout", n, 0);
            end
            return;
        end
        v = {q[0].rs, q[0].b};
        blv = q[0].bl;
        if (!q[0].ok) proto_bad++;
        void'(q.pop_front());
    endtask

    task automatic measure_reset(input string tag);
        int c0;
        int n;
        q.delete();
        @(negedge clk8);
        rst = 1'b0;
        c0 = cyc;
        n = 0;
        while (!lcd_resn && n < 2000) begin
            @(negedge clk8);
            n++;
        end
        chk({tag, "_resn_low"}, cyc - c0, 256);
        c0 = cyc;
        n = 0;
        while (lcd_wrn && n < 3000) begin
            @(negedge clk8);
            n++;
        end
        chk({tag, "_first_wr"}, cyc - c0, 1024);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_csn"}, lcd_csn, 1);
        chk({tag, "_rs"}, lcd_rs, 1);
        chk({tag, "_wrn"}, lcd_wrn, 1);
        chk({tag, "_rdn"}, lcd_rdn, 1);
        chk({tag, "_resn"}, lcd_resn, 0);
        chk({tag, "_db"}, lcd_db, 0);
        chk({tag, "_bl"}, lcd_bl, 0);
    endtask

    task automatic pulse_fmark();
        lcd_fmark = 1'b0;
        repeat (3) @(negedge clk8);
        lcd_fmark = 1'b1;
    endtask

    // Read one whole frame; at pixel a drive keypad to la, at pixel b drive it to lb
    task automatic read_frame(input string tag, input logic [15:0] col, input int a, input logic la, input int b, input logic lb);
        logic [8:0]  v;
        logic        blv;
        logic [15:0] px;
        int          hb = 0;
        int          pb = 0;
        pulse_fmark();
        for (int i = 0; i < 11; i++) begin
            get_wr(v, blv);
            if (v !== win_exp[i]) hb++;
        end
        for (int i = 0; i < NPX; i++) begin
            if (i == a) keypad_up = la;
            if (i == b) keypad_up = lb;
            get_wr(v, blv);
            px[15:8] = v[7:0];
            if (!v[8] || !blv) pb++;
            get_wr(v, blv);
            px[7:0] = v[7:0];
            if (!v[8] || !blv) pb++;
            if (px !== col) pb++;
        end
        chk({tag, "_hdr"}, hb, 0);
        chk({tag, "_px"}, pb, 0);
    endtask

    initial begin
        logic [8:0] v;
        logic       blv;
        int         n;
        #3 rst = 1'b1;
        #1 check_reset_outputs("por");
        repeat (3) @(negedge clk8);
        measure_reset("boot");
        for (int i = 0; i < 10; i++) begin
            get_wr(v, blv);
            chk($sformatf("init%0d", i), v, init_exp[i]);
            if (i == 8) chk("bl_before_dispon", blv, 0);
            if (i == 9) chk("bl_after_dispon", blv, 1);
        end
`ifdef TE_SYNC_EN
        repeat (3000) @(negedge clk8);
        chk("te_held_no_frame", q.size(), 0);
`endif
        read_frame("f1_red", 16'hF800, 100, 1'b0, -1, 1'b1);
        read_frame("f2_green", 16'h07E0, -1, 1'b1, -1, 1'b1);
        read_frame("f3_green", 16'h07E0, 50, 1'b1, 200, 1'b0);
        read_frame("f4_blue", 16'h001F, 50, 1'b1, 200, 1'b0);
        read_frame("f5_white", 16'hFFFF, 50, 1'b1, 200, 1'b0);
        read_frame("f6_wrap_red", 16'hF800, 50, 1'b1, -1, 1'b1);
        chk("bl_kept", lcd_bl, 1);
        chk("csn_kept", lcd_csn, 0);
        pulse_fmark();
        for (int i = 0; i < 71; i++) get_wr(v, blv);
        n = 0;
        while (lcd_wrn && n < 10) begin
            @(negedge clk8);
            n++;
        end
        chk("mid_write_wrn", lcd_wrn, 0);
        #2 rst = 1'b1;
        #1 check_reset_outputs("abort");
        repeat (5) @(negedge clk8);
        measure_reset("restart");
        get_wr(v, blv);
        chk("restart_first", v, 9'h001);
        chk("protocol", proto_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
